// File: rtl/dmux8way16_collector.sv
// dmux8way16_collector
//   Collects a stream of single words into eight registered lanes (a..h).
//   When the frame is complete, it presents all eight lanes at once under a
//   valid/ready handshake.
//
//   The lanes are filled in one of two ways, latched at the first word of a
//   frame:
//     - sequential: lanes a..h in order.
//     - addressed: the lane is chosen by in_addr.
//
//   Optional feature macro: DMUX8WAY16_FLUSH_EN
//     Adds the flush input, which closes a partially filled frame early.
//
// Ports
//   clock      system clock, rising-edge
//   rst_n      synchronous active-low reset
//   mode       0 = sequential fill, 1 = addressed fill
//   in_valid   producer word present on in_data
//   in_ready   collector accepts a word this cycle
//   in_data    word to store
//   in_addr    target lane in addressed mode (0 = a .. 7 = h)
//   out_valid  frame complete, lanes stable
//   out_ready  consumer takes the frame
//   out_a..h   lane registers
//   filled     per-lane written flags (bit i = lane i)
//   flush      (DMUX8WAY16_FLUSH_EN only) close a non-empty frame early
//
// state | meaning
// ------+-----------------------------------------------------------
// FILL  | accepting words into lanes, in_ready high
// HOLD  | frame presented, out_valid high, lanes and flags frozen

module dmux8way16_collector #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_addr,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DMUX8WAY16_FLUSH_EN
    input  logic             flush,
`endif
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] out_e,
    output logic [WIDTH-1:0] out_f,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_h,
    output logic [7:0]       filled
);

    typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q;
    logic [7:0]       filled_q;
    logic             mode_q;
    logic [WIDTH-1:0] lane_q [8];

    logic             accept;
    logic             frame_mode;
    logic [2:0]       wr_idx;
    logic [7:0]       wr_mask;
    logic [7:0]       filled_next;
    logic             handoff;
    logic             do_flush;

    // The mode input only matters on the first word of a frame.
    // After that, the latched copy steers the rest of the frame.
    assign frame_mode  = (filled_q == 8'd0) ? mode : mode_q;
    assign accept      = in_valid && in_ready;
    assign wr_idx      = frame_mode ? in_addr : ptr_q;
    assign wr_mask     = accept ? (8'd1 << wr_idx) : 8'd0;
    assign filled_next = filled_q | wr_mask;
    assign handoff     = out_valid && out_ready;

`ifdef DMUX8WAY16_FLUSH_EN
    // A word accepted with flush is counted first, so a flush on the very
    // first word still produces a one-lane frame.
    assign do_flush = flush && (filled_next != 8'd0);
`else
    assign do_flush = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (accept && !frame_mode && ptr_q == 3'd7) begin
                    state_d = S_HOLD;
                end else if (accept && frame_mode && filled_next == 8'hFF) begin
                    state_d = S_HOLD;
                end else if (do_flush) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Output logic
    // in_ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_FILL:  in_ready  = rst_n;
            S_HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: lanes, fill flags, pointer and mode latch
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            ptr_q    <= 3'd0;
            filled_q <= 8'd0;
            mode_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                lane_q[i] <= '0;
            end
        end else if (handoff) begin
            // Lanes are deliberately retained across the handoff.
            ptr_q    <= 3'd0;
            filled_q <= 8'd0;
        end else if (accept) begin
            lane_q[wr_idx] <= in_data;
            filled_q       <= filled_next;
            if (filled_q == 8'd0) begin
                mode_q <= mode;
            end
            if (!frame_mode) begin
                ptr_q <= ptr_q + 3'd1;
            end
        end
    end

    assign out_a  = lane_q[0];
    assign out_b  = lane_q[1];
    assign out_c  = lane_q[2];
    assign out_d  = lane_q[3];
    assign out_e  = lane_q[4];
    assign out_f  = lane_q[5];
    assign out_g  = lane_q[6];
    assign out_h  = lane_q[7];
    assign filled = filled_q;

endmodule

// File: tb/tb_dmux8way16_collector.sv
module tb_dmux8way16_collector;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_addr;
    logic        out_valid;
    logic        out_ready;
`ifdef DMUX8WAY16_FLUSH_EN
    logic        flush;
`endif
    logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic [7:0]  filled;

    int n_assert = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    always #5 clock = ~clock;

    dmux8way16_collector #(.WIDTH(16)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DMUX8WAY16_FLUSH_EN
        .flush     (flush),
`endif
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_e     (out_e),
        .out_f     (out_f),
        .out_g     (out_g),
        .out_h     (out_h),
        .filled    (filled)
    );

    function automatic logic [15:0] lane(input int i);
        case (i)
            0: return out_a;
            1: return out_b;
            2: return out_c;
            3: return out_d;
            4: return out_e;
            5: return out_f;
            6: return out_g;
            default: return out_h;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1. Acceptance is counted just before the next
    // edge, and outputs are then sampled at posedge+1.
    task automatic step();
        #4;
        if (in_valid && in_ready && rst_n) n_acc++;
        @(posedge clock);
        #1;
    endtask

    task automatic check_lanes(input string tag, input logic [15:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_lane%0d", tag, i), {16'd0, lane(i)}, {16'd0, exp[i]});
        end
    endtask

    logic [15:0] exp_l [8];

    initial begin
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0; out_ready = 1'b0;
`ifdef DMUX8WAY16_FLUSH_EN
        flush = 1'b0;
`endif
        @(posedge clock); #1;
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_filled", {24'd0, filled}, 32'd0);
        for (int i = 0; i < 8; i++) exp_l[i] = 16'h0000;
        check_lanes("rst", exp_l);
        rst_n = 1'b1; #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Sequential frame 1000..1007
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h1000 + 16'(i);
            step();
            if (i == 0) check("seq_lat_a", {16'd0, out_a}, 32'h1000);
            if (i == 6) check("seq_valid_before_last", {31'd0, out_valid}, 32'd0);
        end
        check("seq_out_valid", {31'd0, out_valid}, 32'd1);
        check("seq_in_ready", {31'd0, in_ready}, 32'd0);
        check("seq_filled", {24'd0, filled}, 32'hFF);
        for (int i = 0; i < 8; i++) exp_l[i] = 16'h1000 + 16'(i);
        check_lanes("seq", exp_l);
        // Held for 5 cycles with a stray word offered: nothing may change
        in_data = 16'hDEAD;
        for (int i = 0; i < 5; i++) step();
        check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        check("hold_filled", {24'd0, filled}, 32'hFF);
        check_lanes("hold", exp_l);
        in_valid = 1'b0;

        // Handoff
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ho_out_valid", {31'd0, out_valid}, 32'd0);
        check("ho_in_ready", {31'd0, in_ready}, 32'd1);
        check("ho_filled", {24'd0, filled}, 32'd0);
        check_lanes("ho", exp_l);

        // Addressed frame with an overwrite of lane d
        n_acc = 0;
        mode = 1'b1; in_valid = 1'b1;
        in_addr = 3'd3; in_data = 16'hAAAA; step();
        check("adr_filled1", {24'd0, filled}, 32'h08);
        check("adr_d1", {16'd0, out_d}, 32'hAAAA);
        in_addr = 3'd3; in_data = 16'hBBBB; step();
        check("adr_filled2", {24'd0, filled}, 32'h08);
        check("adr_d2", {16'd0, out_d}, 32'hBBBB);
        in_addr = 3'd0; in_data = 16'h0000; step();
        in_addr = 3'd1; in_data = 16'h0001; step();
        in_addr = 3'd2; in_data = 16'h0002; step();
        in_addr = 3'd4; in_data = 16'h0003; step();
        in_addr = 3'd5; in_data = 16'h0004; step();
        in_addr = 3'd6; in_data = 16'h0005; step();
        check("adr_valid_before_h", {31'd0, out_valid}, 32'd0);
        check("adr_filled_before_h", {24'd0, filled}, 32'h7F);
        in_addr = 3'd7; in_data = 16'h0006; step();
        in_valid = 1'b0;
        check("adr_out_valid", {31'd0, out_valid}, 32'd1);
        check("adr_filled", {24'd0, filled}, 32'hFF);
        check("adr_accepted", n_acc, 32'd9);
        exp_l = '{16'h0000, 16'h0001, 16'h0002, 16'hBBBB, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        check_lanes("adr", exp_l);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Sequential with gaps. Mode flips after the 2nd word, and out_ready
        // is pulsed in FILL; neither may disturb the frame.
        mode = 1'b0; in_addr = 3'd5;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'h2000 + 16'(i);
            step();
            if (i == 1) mode = 1'b1;
            if (i < 7) begin
                in_valid = 1'b0; out_ready = 1'b1;
                step();
                out_ready = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("gap_out_valid", {31'd0, out_valid}, 32'd1);
        check("gap_filled", {24'd0, filled}, 32'hFF);
        for (int i = 0; i < 8; i++) exp_l[i] = 16'h2000 + 16'(i);
        check_lanes("gap", exp_l);
        mode = 1'b0;
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Mid-frame reset discards the partial frame
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'h3000 + 16'(i);
            step();
        end
        check("part_filled", {24'd0, filled}, 32'h0F);
        rst_n = 1'b0; step();
        check("mr_in_ready", {31'd0, in_ready}, 32'd0);
        check("mr_filled", {24'd0, filled}, 32'd0);
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) exp_l[i] = 16'h0000;
        check_lanes("mr", exp_l);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h4000 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        check("post_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 8; i++) exp_l[i] = 16'h4000 + 16'(i);
        check_lanes("post", exp_l);
        out_ready = 1'b1; step(); out_ready = 1'b0;

`ifdef DMUX8WAY16_FLUSH_EN
        // Flush on an empty frame is ignored
        flush = 1'b1; step(); flush = 1'b0;
        check("fl_empty_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_data = 16'h0011; step();
        in_data = 16'h0022; step();
        in_data = 16'h0033; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd1);
        check("fl_filled", {24'd0, filled}, 32'h07);
        check("fl_c", {16'd0, out_c}, 32'h0033);
        check("fl_a", {16'd0, out_a}, 32'h0011);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("fl_ho_in_ready", {31'd0, in_ready}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
